// File: rtl/acl_spi_responder_if.sv
// SPI link between an accelerometer SPI master and the acl_spi_responder stand-in.
// ss is active low; sclk idles high (mode 3).
interface acl_spi_responder_if;
    logic sclk;
    logic ss;
    logic sdi;
    logic sdo;

    modport master (output sclk, output ss, output sdi, input  sdo);
    modport slave  (input  sclk, input  ss, input  sdi, output sdo);
endinterface

// File: rtl/acl_spi_responder.sv
// SPI mode-3 slave emulating the PmodACL (ADXL345-style) register interface.
// Define ACL_SPI_MULTIBYTE_EN to honour the MB command bit (address auto-increment).
module acl_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    acl_spi_responder_if.slave  spi,
    input  logic [15:0]         x_i,
    input  logic [15:0]         y_i,
    input  logic [15:0]         z_i,
    input  logic                sample_valid_i,
    output logic [7:0]          bw_rate_o,
    output logic [7:0]          power_ctl_o,
    output logic [7:0]          int_enable_o,
    output logic [7:0]          data_format_o,
    output logic                wr_strobe_o,
    output logic [5:0]          wr_addr_o,
    output logic                busy_o
);

`ifdef ACL_SPI_MULTIBYTE_EN
    localparam logic MB_EN = 1'b1;
`else
    localparam logic MB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, sdi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, sdi_s;
    logic                   sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [5:0]  addr_q, addr_d;
    logic        mb_q, mb_d;
    logic        sdo_q, sdo_d;
    logic [7:0]  bw_rate_q, bw_rate_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic [7:0]  int_enable_q, int_enable_d;
    logic [7:0]  data_format_q, data_format_d;
    logic        wr_pend_q, wr_pend_d;
    logic        wr_strobe_q;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic        busy_q;

    logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [15:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic        pend_q, pend_d;

    logic [7:0]  rx_byte_s;
    logic [5:0]  next_addr_s;
    logic [5:0]  rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        writable_s;

    // Input synchronizers plus previous-value flops for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= {SYNC_STAGES{1'b1}};
            ss_sync_q   <= {SYNC_STAGES{1'b1}};
            sdi_sync_q  <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi.sdi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign ss_rise_s   = ss_s & ~ss_prev_q;
    assign ss_fall_s   = ~ss_s & ss_prev_q;

    assign rx_byte_s   = {shift_q[6:0], sdi_s};
    assign next_addr_s = addr_q + {5'd0, (mb_q & MB_EN)};
    assign writable_s  = (addr_q == 6'h2C) || (addr_q == 6'h2D) ||
                         (addr_q == 6'h2E) || (addr_q == 6'h31);

    // Register-map read mux: command address when the command completes, else the advanced address.
    always_comb begin
        rd_addr_s = (state_q == ST_CMD) ? rx_byte_s[5:0] : next_addr_s;
        case (rd_addr_s)
            6'h00:   rd_data_s = DEVID;
            6'h2C:   rd_data_s = bw_rate_q;
            6'h2D:   rd_data_s = power_ctl_q;
            6'h2E:   rd_data_s = int_enable_q;
            6'h31:   rd_data_s = data_format_q;
            6'h32:   rd_data_s = x_q[7:0];
            6'h33:   rd_data_s = x_q[15:8];
            6'h34:   rd_data_s = y_q[7:0];
            6'h35:   rd_data_s = y_q[15:8];
            6'h36:   rd_data_s = z_q[7:0];
            6'h37:   rd_data_s = z_q[15:8];
            default: rd_data_s = 8'h00;
        endcase
    end

    // Transaction FSM next-state, shifting and register writes.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        addr_d        = addr_q;
        mb_d          = mb_q;
        sdo_d         = sdo_q;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        int_enable_d  = int_enable_q;
        data_format_d = data_format_q;
        wr_pend_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        if (ss_rise_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end else begin
                        sdo_d = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = rx_byte_s[5:0];
                            mb_d    = rx_byte_s[6];
                            tx_d    = rd_data_s;
                            state_d = rx_byte_s[7] ? ST_READ : ST_WRITE;
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_READ: begin
                    if (sclk_fall_s) begin
                        sdo_d     = tx_q[7];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = next_addr_s;
                            tx_d   = rd_data_s;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (writable_s) begin
                                wr_pend_d = 1'b1;
                                wr_addr_d = addr_q;
                            end else begin
                                wr_pend_d = 1'b0;
                            end
                            case (addr_q)
                                6'h2C:   bw_rate_d     = rx_byte_s;
                                6'h2D:   power_ctl_d   = rx_byte_s;
                                6'h2E:   int_enable_d  = rx_byte_s;
                                6'h31:   data_format_d = rx_byte_s;
                                default: bw_rate_d     = bw_rate_q;
                            endcase
                            addr_d = next_addr_s;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, shift registers, configuration registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            tx_q          <= 8'h00;
            addr_q        <= 6'h00;
            mb_q          <= 1'b0;
            sdo_q         <= 1'b0;
            bw_rate_q     <= 8'h0A;
            power_ctl_q   <= 8'h00;
            int_enable_q  <= 8'h00;
            data_format_q <= 8'h00;
            wr_pend_q     <= 1'b0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= 6'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            mb_q          <= mb_d;
            sdo_q         <= sdo_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            int_enable_q  <= int_enable_d;
            data_format_q <= data_format_d;
            wr_pend_q     <= wr_pend_d;
            wr_strobe_q   <= wr_pend_q;
            wr_addr_q     <= wr_addr_d;
            busy_q        <= ~ss_s;
        end
    end

    // Axis data frozen during a frame; a sample arriving mid-frame waits until the frame ends.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        px_d   = px_q;
        py_d   = py_q;
        pz_d   = pz_q;
        pend_d = pend_q;
        if (state_q == ST_IDLE) begin
            if (sample_valid_i) begin
                x_d    = x_i;
                y_d    = y_i;
                z_d    = z_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                x_d    = px_q;
                y_d    = py_q;
                z_d    = pz_q;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b0;
            end
        end else begin
            if (sample_valid_i) begin
                px_d   = x_i;
                py_d   = y_i;
                pz_d   = z_i;
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Axis data and pending-sample registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= 16'h0000;
            y_q    <= 16'h0000;
            z_q    <= 16'h0000;
            px_q   <= 16'h0000;
            py_q   <= 16'h0000;
            pz_q   <= 16'h0000;
            pend_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            px_q   <= px_d;
            py_q   <= py_d;
            pz_q   <= pz_d;
            pend_q <= pend_d;
        end
    end

    assign spi.sdo       = sdo_q;
    assign bw_rate_o     = bw_rate_q;
    assign power_ctl_o   = power_ctl_q;
    assign int_enable_o  = int_enable_q;
    assign data_format_o = data_format_q;
    assign wr_strobe_o   = wr_strobe_q;
    assign wr_addr_o     = wr_addr_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: directed table, corner sequences and
// randomized frames against a frame-level register-map model.
module tb_acl_spi_responder;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x_in, y_in, z_in;
    logic        sample_valid;
    logic [7:0]  bw_rate_o, power_ctl_o, int_enable_o, data_format_o;
    logic        wr_strobe_o;
    logic [5:0]  wr_addr_o;
    logic        busy_o;

    acl_spi_responder_if spi_if ();

    acl_spi_responder dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .spi            (spi_if),
        .x_i            (x_in),
        .y_i            (y_in),
        .z_i            (z_in),
        .sample_valid_i (sample_valid),
        .bw_rate_o      (bw_rate_o),
        .power_ctl_o    (power_ctl_o),
        .int_enable_o   (int_enable_o),
        .data_format_o  (data_format_o),
        .wr_strobe_o    (wr_strobe_o),
        .wr_addr_o      (wr_addr_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int strobe_seen = 0;

    always @(negedge clk) begin
        if (wr_strobe_o === 1'b1) strobe_seen++;
    end

    // Reference model state
    logic [7:0]  m_reg [0:63];
    logic [15:0] m_x, m_y, m_z, m_px, m_py, m_pz;
    bit          m_pend;
    int          m_strobes = 0;
    logic [5:0]  m_wr_addr;

    logic [7:0]  tx_buf  [0:7];
    logic [7:0]  rx_buf  [0:7];
    logic [7:0]  exp_buf [0:7];
    int          busy_low;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_rx;
        int         exp_strobes;
    } vec_t;
    vec_t vecs [0:11];

    logic [7:0] burst_exp [0:5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            6'h00: return 8'hE5;
            6'h2C, 6'h2D, 6'h2E, 6'h31: return m_reg[a];
            6'h32: return m_x[7:0];
            6'h33: return m_x[15:8];
            6'h34: return m_y[7:0];
            6'h35: return m_y[15:8];
            6'h36: return m_z[7:0];
            6'h37: return m_z[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
        m_reg[6'h2C] = 8'h0A;
        m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
        m_pend = 1'b0;
        m_wr_addr = 6'h00;
    endtask

    // Frame-level semantics: full bytes after the command read or write the addressed register.
    task automatic model_frame(input int nbits);
        logic [5:0] a;
        int nf;
        nf = nbits / 8;
        for (int i = 0; i < 8; i++) exp_buf[i] = 8'h00;
        a = tx_buf[0][5:0];
        for (int i = 1; i < nf; i++) begin
            if (tx_buf[0][7]) exp_buf[i] = m_read(a);
            else if (a == 6'h2C || a == 6'h2D || a == 6'h2E || a == 6'h31) begin
                m_reg[a] = tx_buf[i];
                m_strobes++;
                m_wr_addr = a;
            end
`ifdef ACL_SPI_MULTIBYTE_EN
            if (tx_buf[0][6]) a = a + 6'd1;
`endif
        end
        if (m_pend) begin
            m_x = m_px; m_y = m_py; m_z = m_pz;
            m_pend = 1'b0;
        end
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_in = x; y_in = y; z_in = z;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic idle_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        pulse_sample(x, y, z);
        m_x = x; m_y = y; m_z = z;
        tick(2);
    endtask

    // Mode-3 master: drive on SCLK fall, sample SDO just before SCLK rise.
    task automatic spi_frame(input int nbits, input int pulse_byte,
                             input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz);
        int bi, bp;
        busy_low = 0;
        for (int i = 0; i < 8; i++) rx_buf[i] = 8'h00;
        spi_if.ss = 1'b0;
        tick(8);
        for (int b = 0; b < nbits; b++) begin
            bi = b / 8;
            bp = 7 - (b % 8);
            spi_if.sclk = 1'b0;
            spi_if.sdi  = tx_buf[bi][bp];
            tick(H);
            rx_buf[bi][bp] = spi_if.sdo;
            if (busy_o !== 1'b1) busy_low++;
            spi_if.sclk = 1'b1;
            tick(H);
            if (bp == 0 && bi == pulse_byte) begin
                pulse_sample(px, py, pz);
                m_pend = 1'b1;
                m_px = px; m_py = py; m_pz = pz;
            end
        end
        tick(H);
        spi_if.ss = 1'b1;
        tick(10);
    endtask

    task automatic check_model();
        chk("bw_rate", bw_rate_o, m_reg[6'h2C]);
        chk("power_ctl", power_ctl_o, m_reg[6'h2D]);
        chk("int_enable", int_enable_o, m_reg[6'h2E]);
        chk("data_format", data_format_o, m_reg[6'h31]);
        chk("wr_addr", wr_addr_o, m_wr_addr);
        chk("strobe_count", strobe_seen, m_strobes);
        chk("busy_idle", busy_o, 1'b0);
        chk("sdo_idle", spi_if.sdo, 1'b0);
    endtask

    task automatic do_frame(input int nbits, input int pulse_byte,
                            input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz);
        spi_frame(nbits, pulse_byte, px, py, pz);
        model_frame(nbits);
        for (int i = 0; i < nbits / 8; i++) chk($sformatf("rx_byte%0d", i), rx_buf[i], exp_buf[i]);
        chk("busy_in_frame", busy_low, 0);
        check_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        vecs[0]  = '{8'h80, 8'h00, 8'hE5, 0};
        vecs[1]  = '{8'h2D, 8'h08, 8'h00, 1};
        vecs[2]  = '{8'hAD, 8'h00, 8'h08, 0};
        vecs[3]  = '{8'h00, 8'h55, 8'h00, 0};
        vecs[4]  = '{8'h80, 8'h00, 8'hE5, 0};
        vecs[5]  = '{8'hAC, 8'h00, 8'h0A, 0};
        vecs[6]  = '{8'h2E, 8'h5A, 8'h00, 1};
        vecs[7]  = '{8'hAE, 8'h00, 8'h5A, 0};
        vecs[8]  = '{8'hB1, 8'h00, 8'h00, 0};
        vecs[9]  = '{8'h8F, 8'h00, 8'h00, 0};
        vecs[10] = '{8'h31, 8'h0B, 8'h00, 1};
        vecs[11] = '{8'hB1, 8'h00, 8'h0B, 0};
`ifdef ACL_SPI_MULTIBYTE_EN
        burst_exp = '{8'hF4, 8'h01, 8'h0C, 8'hFE, 8'h00, 8'h01};
`else
        burst_exp = '{8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4};
`endif

        spi_if.sclk = 1'b1; spi_if.ss = 1'b1; spi_if.sdi = 1'b0;
        sample_valid = 1'b0; x_in = 16'h0; y_in = 16'h0; z_in = 16'h0;
        model_reset();
        tick(3);
        chk("rst_sdo", spi_if.sdo, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_bw_rate", bw_rate_o, 8'h0A);
        chk("rst_power_ctl", power_ctl_o, 8'h00);
        chk("rst_data_format", data_format_o, 8'h00);
        chk("rst_wr_strobe", wr_strobe_o, 1'b0);
        chk("rst_wr_addr", wr_addr_o, 6'h00);
        rst_n = 1'b1;
        tick(4);

        // Directed single-byte frames
        for (int v = 0; v < 12; v++) begin
            s0 = strobe_seen;
            tx_buf[0] = vecs[v].cmd;
            tx_buf[1] = vecs[v].data;
            do_frame(16, -1, 16'h0, 16'h0, 16'h0);
            chk($sformatf("vec%0d_rx", v), rx_buf[1], vecs[v].exp_rx);
            chk($sformatf("vec%0d_strobes", v), strobe_seen - s0, vecs[v].exp_strobes);
        end
        chk("power_ctl_written", power_ctl_o, 8'h08);

        // Coherent burst of axis data
        idle_sample(16'h01F4, 16'hFE0C, 16'h0100);
        tx_buf[0] = 8'hF2;
        for (int i = 1; i < 7; i++) tx_buf[i] = 8'h00;
        do_frame(56, -1, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) chk($sformatf("burst_b%0d", i), rx_buf[i+1], burst_exp[i]);

        // Sample arriving mid-burst stays pending until SS rises
        do_frame(56, 2, 16'h7FFF, 16'hFE0C, 16'h0100);
        for (int i = 0; i < 6; i++) chk($sformatf("midburst_b%0d", i), rx_buf[i+1], burst_exp[i]);
        tx_buf[0] = 8'hB2;
        do_frame(16, -1, 16'h0, 16'h0, 16'h0);
        chk("new_x_lo", rx_buf[1], 8'hFF);
        tx_buf[0] = 8'hB3;
        do_frame(16, -1, 16'h0, 16'h0, 16'h0);
        chk("new_x_hi", rx_buf[1], 8'h7F);

        // Partial write byte is discarded
        s0 = strobe_seen;
        tx_buf[0] = 8'h31; tx_buf[1] = 8'hA5;
        do_frame(12, -1, 16'h0, 16'h0, 16'h0);
        chk("partial_data_format", data_format_o, 8'h0B);
        chk("partial_strobes", strobe_seen - s0, 0);

        // Reset in the middle of a READ data byte
        tx_buf[0] = 8'h2C; tx_buf[1] = 8'h33;
        do_frame(16, -1, 16'h0, 16'h0, 16'h0);
        spi_if.ss = 1'b0;
        tick(8);
        for (int b = 0; b < 8; b++) begin
            spi_if.sclk = 1'b0;
            spi_if.sdi  = (b == 0) ? 1'b1 : 1'b0;
            tick(H);
            spi_if.sclk = 1'b1;
            tick(H);
        end
        spi_if.sclk = 1'b0;
        tick(H);
        chk("pre_reset_sdo", spi_if.sdo, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sdo", spi_if.sdo, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_bw_rate", bw_rate_o, 8'h0A);
        spi_if.sclk = 1'b1; spi_if.ss = 1'b1;
        tick(4);
        rst_n = 1'b1;
        model_reset();
        tick(4);
        tx_buf[0] = 8'h80;
        do_frame(16, -1, 16'h0, 16'h0, 16'h0);
        chk("post_rst_devid", rx_buf[1], 8'hE5);
        tx_buf[0] = 8'hB2;
        do_frame(16, -1, 16'h0, 16'h0, 16'h0);
        chk("post_rst_data", rx_buf[1], 8'h00);

        // Randomized frames against the model
        for (int f = 0; f < 50; f++) begin
            logic [5:0] a;
            logic       rw, mb;
            int         nb, pb;
            nb = $urandom_range(2, 3);
            case ($urandom_range(0, 7))
                0: a = 6'h2C;
                1: a = 6'h2D;
                2: a = 6'h2E;
                3: a = 6'h31;
                4: a = 6'h00;
                5: a = 6'h32 + 6'($urandom_range(0, 5));
                default: a = 6'($urandom);
            endcase
            rw = 1'($urandom_range(0, 1));
            mb = 1'($urandom_range(0, 1));
            tx_buf[0] = {rw, mb, a};
            for (int i = 1; i < 8; i++) tx_buf[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                idle_sample(16'($urandom), 16'($urandom), 16'($urandom));
            pb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
            do_frame(nb * 8, pb, 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- SPI slave emulating the PmodACL accelerometer's SPI register interface (ADXL345-style, SPI mode 3).
- Sits on the far end of the accelerometer SPI link. It stands in for the sensor in simulation and board loopback, so the existing SPI master can be exercised without hardware.
- Serves a small register map: DEVID, configuration registers and six axis-data bytes fed from parallel sample inputs.

Parameters:
- DEVID, 8'hE5, value returned at address 0x00.
- SYNC_STAGES, 2, synchronizer depth for SCLK/SS/SDI (min 2).

Ports:
- CLK  in  1  system clock; SCLK must be <= CLK/8.
- RST  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master; idles high (CPOL=1, CPHA=1).
- SS  in  1  chip select from master, active low.
- SDI  in  1  serial data from master (master's SDO).
- SDO  out  1  serial data to master (master's SDI).
- x_in  in  16  X sample, two's complement.
- y_in  in  16  Y sample, two's complement.
- z_in  in  16  Z sample, two's complement.
- sample_valid  in  1  one-CLK pulse; x/y/z_in are valid this cycle.
- bw_rate  out  8  register 0x2C.
- power_ctl  out  8  register 0x2D.
- int_enable  out  8  register 0x2E.
- data_format  out  8  register 0x31.
- wr_strobe  out  1  one-CLK pulse per completed register write.
- wr_addr  out  6  address of the last completed write.
- busy  out  1  high while SS (synchronized) is low.

Behaviour:
- Input conditioning:
  - SCLK, SS and SDI each pass through SYNC_STAGES flops.
  - Rising and falling edges of SCLK are detected on the synchronized copy.
  - All logic runs on CLK.
- Reset (RST=0): state IDLE; SDO=0; bw_rate=8'h0A; power_ctl, int_enable and data_format = 0; data registers = 0; wr_strobe=0; wr_addr=0; busy=0.
- FSM states: IDLE, CMD, READ, WRITE.
  - IDLE -> CMD on synchronized SS falling edge. Clear bit counter; latch the axis data snapshot.
  - CMD: shift SDI in MSB first on each SCLK rising edge. After the 8th rising edge:
    - cmd[7] = R/W (1 = read), cmd[6] = MB, cmd[5:0] = address.
    - Go to READ (load tx shift register with reg[addr]) or WRITE.
  - READ: SDO updates on SCLK falling edges, MSB first.
    - The first falling edge after the command drives bit 7 of the loaded byte.
    - After each 8 data bits the address advances per MB (see Optional Feature) and the next byte is loaded.
  - WRITE: SDI shifts in on rising edges. On each 8th bit, if the address is writable:
    - update the register;
    - pulse wr_strobe one cycle later;
    - set wr_addr.
    - The address then advances per MB.
  - Any state -> IDLE on SS rising edge. Partial bytes are discarded (no write, no strobe). SDO returns to 0 the next cycle.
- Register map (read):
  - 0x00 = DEVID.
  - 0x2C, 0x2D, 0x2E, 0x31 = stored values.
  - 0x32/0x33 = x[7:0]/x[15:8]; 0x34/0x35 = y; 0x36/0x37 = z.
  - All other addresses read 0x00.
- Writable addresses: 0x2C, 0x2D, 0x2E, 0x31. Writes elsewhere are ignored; no wr_strobe.
- Data snapshot and sample update:
  - A sample_valid pulse while IDLE updates the data registers on the next cycle.
  - A sample_valid pulse while busy is held as pending (newest value wins) and applied on the cycle after SS rises. Multi-byte reads are therefore always coherent.
  - sample_valid coincident with the SS falling edge: the new sample is applied first and the snapshot includes it.
- Address advance wraps 0x3F -> 0x00.
- SCLK edges while SS is high are ignored.
- Reset mid-transaction aborts immediately; registers return to reset values.

Optional Feature:
- Macro ACL_SPI_MULTIBYTE_EN.
- Defined: MB=1 increments the address after each data byte; MB=0 keeps the address fixed.
- Undefined: the MB bit is ignored and the address never advances. Repeated bytes re-read or re-write the same register.

Test Plan:
- Reset, then read cmd 0x80 -> SDO returns 0xE5 in byte 2; busy high for the whole frame; no wr_strobe.
- Write cmd 0x2D, data 0x08 -> power_ctl=8'h08; one wr_strobe pulse with wr_addr=6'h2D; readback cmd 0xAD returns 0x08.
- x/y/z_in = 16'h01F4, 16'hFE0C, 16'h0100 with sample_valid, then cmd 0xF2 plus 6 bytes (MB macro defined) -> F4 01 0C FE 00 01.
- Mid-burst pulse sample_valid with x_in=16'h7FFF -> remaining bytes still report the old sample. The next frame reads FF 7F at 0x32/0x33.
- Write cmd 0x00, data 0x55 (read-only address) -> no wr_strobe; DEVID still reads 0xE5. SS deasserted after 4 bits of a write to 0x31 -> data_format unchanged.
- Assert RST during a READ byte -> SDO=0, busy=0, bw_rate=8'h0A immediately. Next frame operates normally.
